// File: rtl/irq_rx_pkg.sv
// Shared definitions for the interrupt event receiver: ID width helper and FSM encoding.
package irq_rx_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } irq_rx_state_t;

    // Guard keeps the id at least one bit wide for degenerate source counts.
    function automatic int calc_id_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/irq_rr_pick.sv
// Combinational round-robin finder: first set request at or after ptr+1, wrapping modulo N.
module irq_rr_pick
    import irq_rx_pkg::*;
#(
    parameter int N   = 8,
    parameter int IDW = calc_id_w(N)
) (
    input  logic [N-1:0]   i_req,
    input  logic [IDW-1:0] i_ptr,
    output logic           o_found,
    output logic [IDW-1:0] o_idx
);

    // Walk from farthest to nearest so the nearest hit is the last assignment.
    always_comb begin
        int             j;
        logic [IDW-1:0] jj;
        o_found = 1'b0;
        o_idx   = '0;
        j       = 0;
        jj      = '0;
        for (int k = N; k >= 1; k--) begin
            j  = (int'(i_ptr) + k) % N;
            jj = IDW'(j);
            if (i_req[jj]) begin
                o_found = 1'b1;
                o_idx   = jj;
            end
        end
    end

endmodule

// File: rtl/irq_event_rx.sv
// Receives async interrupt lines, latches pending/overrun per source and delivers
// one event at a time, round-robin, over a valid/ready handshake.
module irq_event_rx
    import irq_rx_pkg::*;
#(
    parameter int N_IRQ       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8,
    localparam int ID_W       = calc_id_w(N_IRQ)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic [N_IRQ-1:0] irq_mask,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [ID_W-1:0]  evt_id,
    output logic             evt_overrun,
    output logic [N_IRQ-1:0] irq_pending,
    output logic             irq_any,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] ovr_count
);

    logic [N_IRQ-1:0] r_sync [SYNC_STAGES];
    logic [N_IRQ-1:0] r_s_d;
    logic [N_IRQ-1:0] r_pend;
    logic [N_IRQ-1:0] r_ovr;
    logic [ID_W-1:0]  r_ptr;
    logic [ID_W-1:0]  r_evt_id;
    logic             r_evt_ovr;
    logic [CNT_W-1:0] r_cnt;
    irq_rx_state_t    r_state;
    irq_rx_state_t    w_state_nxt;

    logic [N_IRQ-1:0] w_rise;
    logic [N_IRQ-1:0] w_req;
    logic [N_IRQ-1:0] w_clr;
    logic [N_IRQ-1:0] w_ovr_set;
    logic             w_ovr_new;
    logic             w_found;
    logic [ID_W-1:0]  w_idx;
    logic             w_load;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
            r_s_d <= '0;
        end else begin
            r_sync[0] <= irq_in;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
            r_s_d <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_rise = r_sync[SYNC_STAGES-1] & ~r_s_d;
    assign w_req  = r_pend & ~irq_mask;

    irq_rr_pick #(
        .N   (N_IRQ),
        .IDW (ID_W)
    ) u_pick (
        .i_req   (w_req),
        .i_ptr   (r_ptr),
        .o_found (w_found),
        .o_idx   (w_idx)
    );

    // A rise landing on the slot being selected re-arms pend without counting as overrun.
    assign w_clr     = w_load ? (N_IRQ'(1) << w_idx) : '0;
    assign w_ovr_set = w_rise & r_pend & ~w_clr;
    assign w_ovr_new = |(w_ovr_set & ~r_ovr);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pend <= '0;
            r_ovr  <= '0;
        end else begin
            r_pend <= (r_pend & ~w_clr) | w_rise;
            r_ovr  <= (r_ovr & ~w_clr) | w_ovr_set;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (w_found)   w_state_nxt = ST_PRESENT;
            ST_PRESENT: if (evt_ready) w_state_nxt = ST_IDLE;
            default:                   w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_load    = (r_state == ST_IDLE) && w_found;
        evt_valid = (r_state == ST_PRESENT);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ptr     <= ID_W'(N_IRQ - 1);
            r_evt_id  <= '0;
            r_evt_ovr <= 1'b0;
        end else if (w_load) begin
            r_ptr     <= w_idx;
            r_evt_id  <= w_idx;
            r_evt_ovr <= r_ovr[w_idx];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                       r_cnt <= '0;
        else if (cnt_clr)                  r_cnt <= '0;
        else if (w_ovr_new && (~&r_cnt))   r_cnt <= r_cnt + 1'b1;
    end

    assign evt_id      = r_evt_id;
    assign evt_overrun = r_evt_ovr;
    assign irq_pending = r_pend;
    assign irq_any     = (|w_req) | evt_valid;
    assign ovr_count   = r_cnt;

endmodule

// File: tb/tb_irq_event_rx.sv
// Directed self-checking bench for irq_event_rx with default parameters.
module tb_irq_event_rx;

    logic       clk;
    logic       resetn;
    logic [7:0] irq_in;
    logic [7:0] irq_mask;
    logic       evt_valid;
    logic       evt_ready;
    logic [2:0] evt_id;
    logic       evt_overrun;
    logic [7:0] irq_pending;
    logic       irq_any;
    logic       cnt_clr;
    logic [7:0] ovr_count;

    int n_total = 0;
    int n_fail  = 0;

    irq_event_rx dut (
        .clk         (clk),
        .resetn      (resetn),
        .irq_in      (irq_in),
        .irq_mask    (irq_mask),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_id      (evt_id),
        .evt_overrun (evt_overrun),
        .irq_pending (irq_pending),
        .irq_any     (irq_any),
        .cnt_clr     (cnt_clr),
        .ovr_count   (ovr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick(2);
        resetn = 1'b1;
        tick(2);
    endtask

    task automatic pulse(input int k, input int hi, input int lo);
        irq_in[k] = 1'b1;
        tick(hi);
        irq_in[k] = 1'b0;
        tick(lo);
    endtask

    // Waits (bounded) for evt_valid, then checks the presented id and overrun flag.
    task automatic wait_evt(input string tag, input int exp_id, input bit exp_ovr);
        bit seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (evt_valid === 1'b1) seen = 1'b1;
        end
        check({tag, "_valid"}, 32'(seen), 32'd1);
        check({tag, "_id"}, 32'(evt_id), 32'(exp_id));
        check({tag, "_ovr"}, 32'(evt_overrun), 32'(exp_ovr));
    endtask

    initial begin
        bit stable;
        bit extra;

        resetn    = 1'b0;
        irq_in    = '0;
        irq_mask  = '0;
        evt_ready = 1'b0;
        cnt_clr   = 1'b0;
        tick(2);
        check("rst_valid",   32'(evt_valid),   32'd0);
        check("rst_id",      32'(evt_id),      32'd0);
        check("rst_ovr",     32'(evt_overrun), 32'd0);
        check("rst_pending", 32'(irq_pending), 32'd0);
        check("rst_any",     32'(irq_any),     32'd0);
        check("rst_count",   32'(ovr_count),   32'd0);
        resetn = 1'b1;
        tick(2);

        // single source, latency 4 edges
        evt_ready = 1'b1;
        irq_in[3] = 1'b1;
        tick(3);
        check("t1_not_yet", 32'(evt_valid), 32'd0);
        tick(1);
        check("t1_valid",   32'(evt_valid),      32'd1);
        check("t1_id",      32'(evt_id),         32'd3);
        check("t1_ovr",     32'(evt_overrun),    32'd0);
        check("t1_pend3",   32'(irq_pending[3]), 32'd0);
        irq_in[3] = 1'b0;
        tick(1);
        check("t1_accepted", 32'(evt_valid), 32'd0);
        tick(4);
        check("t1_idle_pend", 32'(irq_pending), 32'd0);

        // round-robin from fresh pointer, then wrap from 5
        do_reset();
        evt_ready = 1'b1;
        irq_in = 8'b0010_0101;
        wait_evt("t2_a", 0, 1'b0);
        wait_evt("t2_b", 2, 1'b0);
        wait_evt("t2_c", 5, 1'b0);
        irq_in = '0;
        tick(4);
        irq_in = 8'b0010_0001;
        wait_evt("t2_d", 0, 1'b0);
        wait_evt("t2_e", 5, 1'b0);
        irq_in = '0;
        tick(4);

        // overrun while the consumer stalls
        evt_ready = 1'b0;
        pulse(1, 3, 3);
        tick(2);
        check("t3_first_valid", 32'(evt_valid),   32'd1);
        check("t3_first_id",    32'(evt_id),      32'd1);
        check("t3_first_ovr",   32'(evt_overrun), 32'd0);
        pulse(1, 3, 3);
        pulse(1, 3, 3);
        check("t3_hold_id",  32'(evt_id),         32'd1);
        check("t3_pend1",    32'(irq_pending[1]), 32'd1);
        check("t3_count",    32'(ovr_count),      32'd1);
        evt_ready = 1'b1;
        wait_evt("t3_second", 1, 1'b1);
        tick(3);
        check("t3_drained", 32'(irq_pending), 32'd0);

        // masked source stays pending and silent until unmasked
        irq_mask[4] = 1'b1;
        pulse(4, 3, 3);
        check("t4_pend4", 32'(irq_pending[4]), 32'd1);
        check("t4_any",   32'(irq_any),        32'd0);
        check("t4_valid", 32'(evt_valid),      32'd0);
        irq_mask[4] = 1'b0;
        tick(1);
        check("t4_rel_valid", 32'(evt_valid), 32'd1);
        check("t4_rel_id",    32'(evt_id),    32'd4);
        check("t4_rel_any",   32'(irq_any),   32'd1);
        tick(3);

        // backpressure stability, then reset with src6 held high
        evt_ready = 1'b0;
        pulse(2, 3, 0);
        irq_in[2] = 1'b0;
        wait_evt("t5_hold", 2, 1'b0);
        stable = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (evt_valid !== 1'b1 || evt_id !== 3'd2 || evt_overrun !== 1'b0) stable = 1'b0;
        end
        check("t5_stable", 32'(stable), 32'd1);
        irq_in[6] = 1'b1;
        tick(5);
        resetn = 1'b0;
        #1;
        check("t5_rst_valid",   32'(evt_valid),   32'd0);
        check("t5_rst_id",      32'(evt_id),      32'd0);
        check("t5_rst_pending", 32'(irq_pending), 32'd0);
        check("t5_rst_any",     32'(irq_any),     32'd0);
        check("t5_rst_count",   32'(ovr_count),   32'd0);
        tick(3);
        check("t5_in_rst_valid", 32'(evt_valid), 32'd0);
        resetn    = 1'b1;
        evt_ready = 1'b1;
        wait_evt("t5_after", 6, 1'b0);
        extra = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (evt_valid === 1'b1) extra = 1'b1;
        end
        check("t5_single", 32'(extra), 32'd0);
        irq_in[6] = 1'b0;
        tick(4);

        // saturating overrun counter
        for (int i = 0; i < 300; i++) begin
            irq_mask[0] = 1'b1;
            pulse(0, 2, 2);
            pulse(0, 2, 2);
            irq_mask[0] = 1'b0;
            tick(3);
            if (i == 9) check("t6_count10", 32'(ovr_count), 32'd10);
        end
        check("t6_saturated", 32'(ovr_count), 32'd255);
        irq_mask[0] = 1'b1;
        pulse(0, 2, 2);
        irq_in[0] = 1'b1;
        tick(2);
        cnt_clr = 1'b1;
        tick(1);
        cnt_clr = 1'b0;
        check("t6_clr_wins", 32'(ovr_count), 32'd0);
        irq_in[0] = 1'b0;
        tick(3);
        check("t6_no_recount", 32'(ovr_count), 32'd0);
        irq_mask[0] = 1'b0;
        tick(4);

        $display("%0d/%0d checks passed", n_total - n_fail, n_total);
        $finish;
    end

endmodule
